// File: rtl/data_mem_v2.sv
// Parametrised single-port data RAM with per-lane write enables, optional
// registered read path and a hardware clear engine that zeroes every word.
module data_mem_v2 #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int REG_READ   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] DataAddress,
  input  logic                  ReadMem,
  input  logic                  WriteMem,
  input  logic [LANES-1:0]      ByteEn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ClearReq,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  ReadValid,
  output logic                  Busy
);

  localparam int LW    = DATA_WIDTH / LANES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clrAddr;
  logic                  r_busy;
  logic                  w_write;

  // ClearReq wins over any access presented in the same IDLE cycle.
  assign w_write = (r_state == ST_IDLE) & ~ClearReq & WriteMem;
  assign Busy    = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
      r_busy    <= 1'b1;
    end else if (r_state == ST_CLEAR) begin
      r_clrAddr <= r_clrAddr + ADDR_WIDTH'(1);
      if (r_clrAddr == '1) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end else if (ClearReq) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
      r_busy    <= 1'b1;
    end
  end

  // The array has no reset; the clear engine is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clrAddr] <= '0;
    end else if (w_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (ByteEn[i]) begin
          r_mem[DataAddress][i*LW +: LW] <= DataIn[i*LW +: LW];
        end
      end
    end
  end

  generate
    if (REG_READ != 0) begin : g_regRead
      logic [DATA_WIDTH-1:0] r_dataOut;
      logic                  r_readValid;
      logic                  w_read;

      assign w_read = (r_state == ST_IDLE) & ~ClearReq & ReadMem;

      // Reads sample the array before this edge's write lands (old data).
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dataOut   <= '0;
          r_readValid <= 1'b0;
        end else begin
          r_readValid <= w_read;
          if (w_read) begin
            r_dataOut <= r_mem[DataAddress];
          end
        end
      end

      assign DataOut   = r_dataOut;
      assign ReadValid = r_readValid;
    end else begin : g_combRead
      assign DataOut   = r_busy ? '0 : r_mem[DataAddress];
      assign ReadValid = ReadMem & ~r_busy;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_v2.sv
// Bench for data_mem_v2: three instances (default, 2-lane 16-bit, registered
// read) driven by feature tasks with queue-based expected read data.
module tb_data_mem_v2;

  logic clk;
  int   checks;
  int   errors;

  // Default configuration: 256 x 8, one lane, combinational read
  logic       cReset, cRd, cWr, cClr, cRv, cBusy;
  logic [7:0] cAddr, cDin, cDout;
  logic [0:0] cBe;
  // 16 x 16, two byte lanes, combinational read
  logic        lReset, lRd, lWr, lClr, lRv, lBusy;
  logic [3:0]  lAddr;
  logic [15:0] lDin, lDout;
  logic [1:0]  lBe;
  // 16 x 8, one lane, registered read
  logic       rReset, rRd, rWr, rClr, rRv, rBusy;
  logic [3:0] rAddr;
  logic [7:0] rDin, rDout;
  logic [0:0] rBe;

  logic [7:0]  cModel [256];
  logic [15:0] lModel [16];
  logic [7:0]  rModel [16];
  logic [7:0]  cQ [$];
  logic [15:0] lQ [$];
  logic [7:0]  rQ [$];

  data_mem_v2 #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LANES(1), .REG_READ(0)) dutC (
    .clk(clk), .reset(cReset), .DataAddress(cAddr), .ReadMem(cRd), .WriteMem(cWr),
    .ByteEn(cBe), .DataIn(cDin), .ClearReq(cClr), .DataOut(cDout),
    .ReadValid(cRv), .Busy(cBusy));

  data_mem_v2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANES(2), .REG_READ(0)) dutL (
    .clk(clk), .reset(lReset), .DataAddress(lAddr), .ReadMem(lRd), .WriteMem(lWr),
    .ByteEn(lBe), .DataIn(lDin), .ClearReq(lClr), .DataOut(lDout),
    .ReadValid(lRv), .Busy(lBusy));

  data_mem_v2 #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANES(1), .REG_READ(1)) dutR (
    .clk(clk), .reset(rReset), .DataAddress(rAddr), .ReadMem(rRd), .WriteMem(rWr),
    .ByteEn(rBe), .DataIn(rDin), .ClearReq(rClr), .DataOut(rDout),
    .ReadValid(rRv), .Busy(rBusy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write helpers drive one write for one edge and keep the model in step.
  task automatic cWrite(input logic [7:0] a, input logic [7:0] d);
    cAddr = a; cDin = d; cBe = 1'b1; cWr = 1'b1;
    @(posedge clk); #1;
    cWr = 1'b0;
    cModel[a] = d;
  endtask

  task automatic lWrite(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    lAddr = a; lDin = d; lBe = be; lWr = 1'b1;
    @(posedge clk); #1;
    lWr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (be[i]) lModel[a][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic rWrite(input logic [3:0] a, input logic [7:0] d);
    rAddr = a; rDin = d; rBe = 1'b1; rWr = 1'b1;
    @(posedge clk); #1;
    rWr = 1'b0;
    rModel[a] = d;
  endtask

  task automatic test_reset();
    cRd = 1'b1; lRd = 1'b1; rRd = 1'b1;
    #1;
    checks++; if (cBusy !== 1'b1) begin errors++; $display("FAIL reset_cBusy: got %b expected 1", cBusy); end
    checks++; if (cRv !== 1'b0) begin errors++; $display("FAIL reset_cValid: got %b expected 0", cRv); end
    checks++; if (cDout !== 8'h00) begin errors++; $display("FAIL reset_cDout: got %h expected 00", cDout); end
    checks++; if (lBusy !== 1'b1) begin errors++; $display("FAIL reset_lBusy: got %b expected 1", lBusy); end
    checks++; if (lRv !== 1'b0) begin errors++; $display("FAIL reset_lValid: got %b expected 0", lRv); end
    checks++; if (lDout !== 16'h0000) begin errors++; $display("FAIL reset_lDout: got %h expected 0000", lDout); end
    checks++; if (rBusy !== 1'b1) begin errors++; $display("FAIL reset_rBusy: got %b expected 1", rBusy); end
    checks++; if (rRv !== 1'b0) begin errors++; $display("FAIL reset_rValid: got %b expected 0", rRv); end
    checks++; if (rDout !== 8'h00) begin errors++; $display("FAIL reset_rDout: got %h expected 00", rDout); end
    cRd = 1'b0; lRd = 1'b0; rRd = 1'b0;
    @(posedge clk); #1;
    cReset = 1'b0; lReset = 1'b0; rReset = 1'b0;
  endtask

  task automatic test_clear_timing();
    int cDone, lDone, rDone;
    logic [15:0] exp16;
    logic [7:0]  exp8;
    cDone = 0; lDone = 0; rDone = 0;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (!cBusy && cDone == 0) cDone = e;
      if (!lBusy && lDone == 0) lDone = e;
      if (!rBusy && rDone == 0) rDone = e;
      if (cDone != 0 && lDone != 0 && rDone != 0) break;
    end
    checks++; if (cDone != 256) begin errors++; $display("FAIL clear_edges_c: got %0d expected 256", cDone); end
    checks++; if (lDone != 16) begin errors++; $display("FAIL clear_edges_l: got %0d expected 16", lDone); end
    checks++; if (rDone != 16) begin errors++; $display("FAIL clear_edges_r: got %0d expected 16", rDone); end
    for (int i = 0; i < 16; i++) begin
      lWrite(4'(i), 16'($urandom_range(1, 65535)), 2'b11);
      rWrite(4'(i), 8'($urandom_range(1, 255)));
    end
    lReset = 1'b1; rReset = 1'b1;
    @(posedge clk); #1;
    lReset = 1'b0; rReset = 1'b0;
    lDone = 0; rDone = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (!lBusy && lDone == 0) lDone = e;
      if (!rBusy && rDone == 0) rDone = e;
      if (lDone != 0 && rDone != 0) break;
    end
    checks++; if (lDone != 16) begin errors++; $display("FAIL reclear_edges_l: got %0d expected 16", lDone); end
    checks++; if (rDone != 16) begin errors++; $display("FAIL reclear_edges_r: got %0d expected 16", rDone); end
    for (int i = 0; i < 16; i++) begin
      lModel[i] = '0;
      rModel[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      lAddr = 4'(i); lRd = 1'b1;
      lQ.push_back(lModel[i]);
      #1;
      exp16 = lQ.pop_front();
      checks++; if (lDout !== exp16 || lRv !== 1'b1) begin errors++; $display("FAIL cleared_l[%0d]: got %h/%b expected %h/1", i, lDout, lRv, exp16); end
      @(posedge clk); #1;
    end
    lRd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rAddr = 4'(i); rRd = 1'b1;
      rQ.push_back(rModel[i]);
      @(posedge clk); #1;
      exp8 = rQ.pop_front();
      checks++; if (rDout !== exp8 || rRv !== 1'b1) begin errors++; $display("FAIL cleared_r[%0d]: got %h/%b expected %h/1", i, rDout, rRv, exp8); end
    end
    rRd = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    int n;
    cWrite(8'h3C, 8'hA5);
    cAddr = 8'h3C; cRd = 1'b1; cQ.push_back(8'hA5); #1;
    exp = cQ.pop_front();
    checks++; if (cDout !== exp || cRv !== 1'b1) begin errors++; $display("FAIL basic_rd3C: got %h/%b expected %h/1", cDout, cRv, exp); end
    @(posedge clk); #1; cRd = 1'b0;
    cWrite(8'h3D, 8'h5A);
    cAddr = 8'h3D; cRd = 1'b1; cQ.push_back(8'h5A); #1;
    exp = cQ.pop_front();
    checks++; if (cDout !== exp || cRv !== 1'b1) begin errors++; $display("FAIL basic_rd3D: got %h/%b expected %h/1", cDout, cRv, exp); end
    cRd = 1'b0; cAddr = 8'h3C; cQ.push_back(cModel[8'h3C]); #1;
    exp = cQ.pop_front();
    checks++; if (cDout !== exp || cRv !== 1'b0) begin errors++; $display("FAIL basic_noread: got %h/%b expected %h/0", cDout, cRv, exp); end
    @(posedge clk); #1;
    // Request a clear, then hold a write and a read on 0x3C for the whole clear
    cClr = 1'b1;
    @(posedge clk); #1;
    cClr = 1'b0;
    cAddr = 8'h3C; cDin = 8'hFF; cWr = 1'b1; cRd = 1'b1; #1;
    checks++; if (cBusy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", cBusy); end
    checks++; if (cDout !== 8'h00 || cRv !== 1'b0) begin errors++; $display("FAIL basic_busy_read: got %h/%b expected 00/0", cDout, cRv); end
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      n++;
      if (!cBusy) break;
    end
    cWr = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL basic_clear_edges: got %0d expected 256", n); end
    for (int i = 0; i < 256; i++) cModel[i] = '0;
    cQ.push_back(cModel[8'h3C]); #1;
    exp = cQ.pop_front();
    checks++; if (cDout !== exp || cRv !== 1'b1) begin errors++; $display("FAIL basic_after_clear: got %h/%b expected %h/1", cDout, cRv, exp); end
    @(posedge clk); #1; cRd = 1'b0;
  endtask

  task automatic test_lanes();
    logic [15:0] exp;
    logic [15:0] data [4];
    logic [1:0]  mask [4];
    logic [15:0] want [4];
    data[0] = 16'h1234; mask[0] = 2'b11; want[0] = 16'h1234;
    data[1] = 16'hABCD; mask[1] = 2'b01; want[1] = 16'h12CD;
    data[2] = 16'hFFFF; mask[2] = 2'b00; want[2] = 16'h12CD;
    data[3] = 16'h5600; mask[3] = 2'b10; want[3] = 16'h56CD;
    for (int s = 0; s < 4; s++) begin
      lWrite(4'h3, data[s], mask[s]);
      lAddr = 4'h3; lRd = 1'b1; lQ.push_back(want[s]); #1;
      exp = lQ.pop_front();
      checks++; if (lDout !== exp || lRv !== 1'b1) begin errors++; $display("FAIL lanes_step%0d: got %h/%b expected %h/1", s, lDout, lRv, exp); end
      @(posedge clk); #1; lRd = 1'b0;
    end
  endtask

  task automatic test_regread();
    logic [7:0] exp;
    rWrite(4'h5, 8'h11);
    rAddr = 4'h5; rRd = 1'b1; rWr = 1'b1; rDin = 8'h22; rBe = 1'b1;
    rQ.push_back(8'h11);
    @(posedge clk); #1;
    rWr = 1'b0; rModel[5] = 8'h22;
    exp = rQ.pop_front();
    checks++; if (rDout !== exp || rRv !== 1'b1) begin errors++; $display("FAIL regread_old: got %h/%b expected %h/1", rDout, rRv, exp); end
    rQ.push_back(8'h22);
    @(posedge clk); #1;
    rRd = 1'b0;
    exp = rQ.pop_front();
    checks++; if (rDout !== exp || rRv !== 1'b1) begin errors++; $display("FAIL regread_new: got %h/%b expected %h/1", rDout, rRv, exp); end
    @(posedge clk); #1;
    checks++; if (rDout !== 8'h22 || rRv !== 1'b0) begin errors++; $display("FAIL regread_hold: got %h/%b expected 22/0", rDout, rRv); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) rWrite(4'(i), 8'(8'h40 + i * 3));
    for (int i = 0; i < 8; i++) begin
      rAddr = 4'((i * 5) % 8); rRd = 1'b1;
      rQ.push_back(rModel[(i * 5) % 8]);
      @(posedge clk); #1;
      exp = rQ.pop_front();
      checks++; if (rDout !== exp || rRv !== 1'b1) begin errors++; $display("FAIL b2b_read%0d: got %h/%b expected %h/1", i, rDout, rRv, exp); end
    end
    rRd = 1'b0;
  endtask

  task automatic test_clear_collision();
    logic [15:0] exp;
    int n;
    lWrite(4'h7, 16'h1111, 2'b11);
    lClr = 1'b1; lWr = 1'b1; lAddr = 4'h7; lDin = 16'hBEEF; lBe = 2'b11;
    @(posedge clk); #1;
    lClr = 1'b0; lWr = 1'b0; lRd = 1'b1; #1;
    checks++; if (lBusy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b expected 1", lBusy); end
    checks++; if (lDout !== 16'h0000 || lRv !== 1'b0) begin errors++; $display("FAIL collide_busy_read: got %h/%b expected 0000/0", lDout, lRv); end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      lClr = (k == 5);
      @(posedge clk); #1;
      n++;
      if (!lBusy) break;
    end
    lClr = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL collide_clear_edges: got %0d expected 16", n); end
    for (int i = 0; i < 16; i++) lModel[i] = '0;
    lAddr = 4'h7; lQ.push_back(lModel[7]); #1;
    exp = lQ.pop_front();
    checks++; if (lDout !== exp || lRv !== 1'b1) begin errors++; $display("FAIL collide_addr7: got %h/%b expected %h/1", lDout, lRv, exp); end
    lAddr = 4'h3; lQ.push_back(lModel[3]); #1;
    exp = lQ.pop_front();
    checks++; if (lDout !== exp || lRv !== 1'b1) begin errors++; $display("FAIL collide_addr3: got %h/%b expected %h/1", lDout, lRv, exp); end
    @(posedge clk); #1; lRd = 1'b0;
  endtask

  task automatic test_reset_midclear();
    logic [7:0] exp;
    int lDone, rDone;
    lClr = 1'b1;
    @(posedge clk); #1;
    lClr = 1'b0; lRd = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rAddr = 4'h5; rRd = 1'b1; rQ.push_back(rModel[5]);
    @(posedge clk); #1;
    rRd = 1'b0;
    exp = rQ.pop_front();
    checks++; if (rDout !== exp || rRv !== 1'b1) begin errors++; $display("FAIL midclear_preread: got %h/%b expected %h/1", rDout, rRv, exp); end
    // Assert reset between edges; outputs must react with no clock edge
    #2;
    lReset = 1'b1; rReset = 1'b1;
    #1;
    checks++; if (rDout !== 8'h00 || rRv !== 1'b0) begin errors++; $display("FAIL async_reset_r: got %h/%b expected 00/0", rDout, rRv); end
    checks++; if (rBusy !== 1'b1) begin errors++; $display("FAIL async_reset_rBusy: got %b expected 1", rBusy); end
    checks++; if (lDout !== 16'h0000 || lRv !== 1'b0 || lBusy !== 1'b1) begin errors++; $display("FAIL async_reset_l: got %h/%b/%b expected 0000/0/1", lDout, lRv, lBusy); end
    @(posedge clk); #1;
    lReset = 1'b0; rReset = 1'b0;
    lDone = 0; rDone = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (!lBusy && lDone == 0) lDone = e;
      if (!rBusy && rDone == 0) rDone = e;
      if (lDone != 0 && rDone != 0) break;
    end
    lRd = 1'b0;
    checks++; if (lDone != 16) begin errors++; $display("FAIL midclear_edges_l: got %0d expected 16", lDone); end
    checks++; if (rDone != 16) begin errors++; $display("FAIL midclear_edges_r: got %0d expected 16", rDone); end
    for (int i = 0; i < 16; i++) rModel[i] = '0;
    rAddr = 4'h5; rRd = 1'b1; rQ.push_back(rModel[5]);
    @(posedge clk); #1;
    rRd = 1'b0;
    exp = rQ.pop_front();
    checks++; if (rDout !== exp || rRv !== 1'b1) begin errors++; $display("FAIL midclear_addr5: got %h/%b expected %h/1", rDout, rRv, exp); end
  endtask

  initial begin
    checks = 0; errors = 0;
    cReset = 1'b0; lReset = 1'b0; rReset = 1'b0;
    cRd = 0; cWr = 0; cClr = 0; cAddr = '0; cDin = '0; cBe = '0;
    lRd = 0; lWr = 0; lClr = 0; lAddr = '0; lDin = '0; lBe = '0;
    rRd = 0; rWr = 0; rClr = 0; rAddr = '0; rDin = '0; rBe = '0;
    for (int i = 0; i < 256; i++) cModel[i] = '0;
    for (int i = 0; i < 16; i++) begin lModel[i] = '0; rModel[i] = '0; end
    #2;
    cReset = 1'b1; lReset = 1'b1; rReset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_clear_timing();
    test_basic();
    test_lanes();
    test_regread();
    test_back_to_back();
    test_clear_collision();
    test_reset_midclear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_v2.md
Name: data_mem_v2

Overview:
Parametrised successor to the single-port data memory.
- Adds per-lane write enables, a selectable registered read path with a valid flag, and a hardware clear engine.
- The clear engine zeroes every word after reset or on request.
- Sits between the datapath load/store unit and the core's address/data buses; acts as the processor's data RAM.

Parameters:
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words.
DATA_WIDTH, 8, word width in bits.
LANES, 1, write lanes per word; DATA_WIDTH must be divisible by LANES; lane width LW = DATA_WIDTH/LANES.
REG_READ, 0, 0 = combinational read, 1 = one-cycle registered read.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
DataAddress  input  ADDR_WIDTH  word address for read and write.
ReadMem  input  1  read request.
WriteMem  input  1  write request.
ByteEn  input  LANES  lane write mask; lane i covers bits [i*LW +: LW].
DataIn  input  DATA_WIDTH  write data.
ClearReq  input  1  request full-memory clear (one-cycle pulse or level).
DataOut  output  DATA_WIDTH  read data.
ReadValid  output  1  DataOut holds valid read data.
Busy  output  1  clear engine active; accesses ignored.

Behaviour:
Reset (asynchronous):
- State goes to CLEAR and ClrAddr to 0.
- Busy = 1, ReadValid = 0.
- The REG_READ=1 DataOut register goes to 0.
- Memory array is not reset directly. The clear engine zeroes it.

State machine (two states, CLEAR and IDLE):
- CLEAR: on each rising edge with reset low, mem[ClrAddr] <= 0 and ClrAddr increments.
- CLEAR: on the edge that writes address 2**ADDR_WIDTH-1, go to IDLE.
- CLEAR lasts exactly 2**ADDR_WIDTH edges after reset deasserts. Busy = (state == CLEAR).
- IDLE: ClearReq=1 at an edge sets state to CLEAR and ClrAddr to 0.
- IDLE: ClearReq has priority; any WriteMem/ReadMem in that same cycle is dropped (no write, ReadValid=0 next cycle).
- ClearReq during CLEAR is ignored; the clear does not restart.
- Reset asserted mid-clear restarts the clear from address 0.

Write (IDLE, no ClearReq):
- At the edge with WriteMem=1, each lane i with ByteEn[i]=1 gets mem[DataAddress] lane i <= DataIn lane i.
- Lanes with ByteEn[i]=0 keep their old value.
- ByteEn all-zero means no change.

Read, REG_READ=0:
- DataOut = mem[DataAddress] combinationally when Busy=0, else 0.
- ReadValid = ReadMem & ~Busy.
- A write is visible on DataOut after the write edge.

Read, REG_READ=1:
- At an edge with ReadMem=1 and Busy=0 (and no ClearReq): DataOut <= mem[DataAddress] and ReadValid <= 1.
- Otherwise ReadValid <= 0 and DataOut holds its last value.
- Read and write to the same address at the same edge return the old (pre-write) data.
- Latency is 1 cycle; back-to-back reads give one result per cycle.

Accesses while Busy: WriteMem and ReadMem are ignored with no side effects.

Address width: DataAddress covers the full array; there is no out-of-range case.

Test Plan:
1. Clear timing (ADDR_WIDTH=4): preload random contents via backdoor, pulse reset → Busy high for exactly 16 edges after deassert, then 0; all 16 words read 0.
2. Basic access (REG_READ=0, LANES=1): write 0xA5 to addr 0x3C, then read addr 0x3C → DataOut=0xA5 with ReadValid=1 in the same cycle; during Busy, DataOut=0 and ReadValid=0.
3. Lane mask (DATA_WIDTH=16, LANES=2): write 0x1234 with ByteEn=2'b11, then 0xABCD with ByteEn=2'b01 → read returns 0x12CD; ByteEn=2'b00 write leaves 0x12CD.
4. Registered read (REG_READ=1): read addr 5 (holding 0x11) while writing 0x22 to addr 5 at the same edge → next cycle DataOut=0x11, ReadValid=1; following read returns 0x22.
5. ClearReq collision: in IDLE, assert ClearReq with WriteMem to addr 7 → Busy next cycle; after 2**ADDR_WIDTH edges addr 7 reads 0; a ClearReq pulse mid-clear does not extend Busy.
6. Reset mid-clear: assert reset at ClrAddr=9, release → Busy lasts the full 2**ADDR_WIDTH edges; ReadValid=0 and DataOut=0 immediately on reset assertion, without waiting for a clock edge.
